// File: rtl/exec_instr_driver_if.sv
// Shared opcode types and the load/issue bus between the driver and exec unit.
// The driver side is master; loader and exec unit together form the slave side.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif

package exec_instr_pkg;
    typedef struct packed {
        logic AND;
        logic TAD;
        logic ISZ;
        logic DCA;
        logic JMS;
        logic JMP;
        logic [`ADDR_WIDTH-1:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic NOP;
        logic IAC;
        logic RAL;
        logic RTL;
        logic RAR;
        logic RTR;
        logic CML;
        logic CMA;
        logic CIA;
        logic CLL;
        logic CLA1;
        logic CLA_CLL;
        logic HLT;
        logic OSR;
        logic SKP;
        logic SNL;
        logic SZL;
        logic SZA;
        logic SNA;
        logic SMA;
        logic SPA;
        logic CLA2;
    } pdp_op7_opcode_s;
endpackage

interface exec_instr_driver_if;
    import exec_instr_pkg::*;

    logic                   load_valid;
    logic                   load_ready;
    logic [4:0]             load_sel;
    logic [`ADDR_WIDTH-1:0] load_addr;
    pdp_mem_opcode_s        pdp_mem_opcode;
    pdp_op7_opcode_s        pdp_op7_opcode;
    logic                   stall;

    modport master (
        input  load_valid, load_sel, load_addr, stall,
        output load_ready, pdp_mem_opcode, pdp_op7_opcode
    );

    modport slave (
        output load_valid, load_sel, load_addr, stall,
        input  load_ready, pdp_mem_opcode, pdp_op7_opcode
    );
endinterface

// File: rtl/exec_instr_driver.sv
// Buffers decoded instructions in a FIFO and issues them one at a time
// as one-hot opcodes, following the exec unit's stall handshake.
module exec_instr_driver
    import exec_instr_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int STALL_TIMEOUT = 16,
    parameter int COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    exec_instr_driver_if.master bus,
    output logic               busy,
    output logic               halted,
    output logic               timeout_err,
    output logic [COUNT_W-1:0] issue_count,
    output logic               fifo_empty,
    output logic               fifo_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(STALL_TIMEOUT + 1);

    localparam logic [4:0] SEL_OP7 = 5'd6;
    localparam logic [4:0] SEL_HLT = 5'd15;
    localparam logic [4:0] SEL_MAX = 5'd27;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    typedef struct packed {
        logic [4:0]             sel;
        logic [`ADDR_WIDTH-1:0] addr;
    } entry_t;

    state_t          state;
    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     cnt_nxt;
    logic [TW-1:0]   wait_cnt;
    logic            cur_hlt;
    logic            push;
    logic            pop;
    pdp_mem_opcode_s mem_nxt;
    pdp_op7_opcode_s op7_nxt;

    assign bus.load_ready = ~fifo_full;
    assign head = mem_q[rd_ptr];

    assign pop = (state == IDLE) & ~fifo_empty & ~halted
               & ~bus.stall & ~timeout_err;

    // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
    assign push = bus.load_valid & (bus.load_sel <= SEL_MAX)
                & (~fifo_full | pop);

    assign cnt_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_comb begin
        mem_nxt = '0;
        op7_nxt = '0;
        if (head.sel < SEL_OP7)
            mem_nxt = {6'(1) << head.sel, head.addr};
        else
            op7_nxt = 22'(1) << (head.sel - SEL_OP7);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr] <= {bus.load_sel, bus.load_addr};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count      <= cnt_nxt;
            fifo_empty <= (cnt_nxt == '0);
            fifo_full  <= (cnt_nxt == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state              <= IDLE;
            busy               <= 1'b0;
            halted             <= 1'b0;
            timeout_err        <= 1'b0;
            issue_count        <= '0;
            wait_cnt           <= '0;
            cur_hlt            <= 1'b0;
            bus.pdp_mem_opcode <= '0;
            bus.pdp_op7_opcode <= '0;
        end else begin
            if (start)
                halted <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.pdp_mem_opcode <= mem_nxt;
                        bus.pdp_op7_opcode <= op7_nxt;
                        cur_hlt            <= (head.sel == SEL_HLT);
                        wait_cnt           <= '0;
                        busy               <= 1'b1;
                        state              <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.stall) begin
                        bus.pdp_mem_opcode <= '0;
                        bus.pdp_op7_opcode <= '0;
                        state              <= BUSY;
                    end else if (wait_cnt == TW'(STALL_TIMEOUT)) begin
                        bus.pdp_mem_opcode <= '0;
                        bus.pdp_op7_opcode <= '0;
                        timeout_err        <= 1'b1;
                        busy               <= 1'b0;
                        state              <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                BUSY: begin
                    // Retire on stall falling; a retired HLT overrides start.
                    if (!bus.stall) begin
                        issue_count <= issue_count + 1'b1;
                        if (cur_hlt)
                            halted <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_instr_driver.sv
// Scoreboard bench: issued opcodes are checked against a queue of expected
// entries by a monitor, while a responder models the exec unit's stall.
module tb_exec_instr_driver;
    import exec_instr_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        halted;
    logic        timeout_err;
    logic [15:0] issue_count;
    logic        fifo_empty;
    logic        fifo_full;

    exec_instr_driver_if bus ();

    exec_instr_driver #(
        .DEPTH(8),
        .STALL_TIMEOUT(16),
        .COUNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .bus(bus),
        .busy(busy),
        .halted(halted),
        .timeout_err(timeout_err),
        .issue_count(issue_count),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int issues = 0;
    int cur_hold = 0;
    int last_hold = 0;
    int fall_cyc = 0;
    int fall_cnt = 0;
    int seen_fall = 0;
    int rstate = 0;
    int resp_mode = 0;
    int resp_len = 1;
    int resp_delay = 0;
    bit chk_gap = 0;
    logic [39:0] sb[$];

    function automatic logic [39:0] op_now();
        return {bus.pdp_mem_opcode, bus.pdp_op7_opcode};
    endfunction

    function automatic logic [39:0] expv(logic [4:0] sel, logic [11:0] addr);
        logic [17:0] m;
        logic [21:0] o;
        m = '0;
        o = '0;
        if (sel < 5'd6)
            m = (18'h1 << (12 + sel)) | {6'd0, addr};
        else
            o = 22'h1 << (sel - 5'd6);
        return {m, o};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [39:0] op;
        logic [39:0] prev;
        logic [39:0] exp;
        prev = '0;
        forever begin
            @(negedge clk);
            op = op_now();
            if (op != 0 && prev == 0) begin
                cur_hold = 1;
                issues++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL issue_unexpected: got %0h want none", op);
                end else begin
                    exp = sb.pop_front();
                    check("issue_order", op, exp);
                end
                if (chk_gap && fall_cnt != seen_fall)
                    check("idle_gap", cyc - fall_cyc, 2);
                seen_fall = fall_cnt;
            end else if (op != 0) begin
                cur_hold++;
            end else if (prev != 0) begin
                last_hold = cur_hold;
            end
            prev = op;
        end
    endtask

    task automatic responder();
        int dly;
        int rem;
        dly = 0;
        rem = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rstate = 0;
                bus.stall = 1'b0;
            end else begin
                case (rstate)
                    0: begin
                        bus.stall = (resp_mode == 2);
                        if (resp_mode == 0 && op_now() != 0) begin
                            if (resp_delay == 0) begin
                                bus.stall = 1'b1;
                                rem = resp_len - 1;
                                rstate = 2;
                            end else begin
                                dly = resp_delay - 1;
                                rstate = 1;
                            end
                        end
                    end
                    1: begin
                        if (dly == 0) begin
                            bus.stall = 1'b1;
                            rem = resp_len - 1;
                            rstate = 2;
                        end else begin
                            dly--;
                        end
                    end
                    default: begin
                        if (rem == 0) begin
                            bus.stall = 1'b0;
                            fall_cyc = cyc;
                            fall_cnt++;
                            rstate = 0;
                        end else begin
                            rem--;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic push(logic [4:0] sel, logic [11:0] addr, bit acc);
        @(posedge clk);
        #1;
        bus.load_valid = 1'b1;
        bus.load_sel = sel;
        bus.load_addr = addr;
        if (acc)
            sb.push_back(expv(sel, addr));
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
    endtask

    task automatic drain(string name, int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (fifo_empty && !busy && sb.size() == 0
                && rstate == 0 && !bus.stall) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        int base;
        bit ok;
        reset_n = 1'b0;
        start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_sel = '0;
        bus.load_addr = '0;
        bus.stall = 1'b0;
        fork
            monitor();
            responder();
            forever @(posedge clk) cyc++;
            begin
                #500000;
                $display("FAIL watchdog: got timeout want finish");
                $fatal(1);
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_count", issue_count, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_ready", bus.load_ready, 1);
        check("rst_opcode", op_now(), 0);

        // AND @ 0o120 held for delay+1 cycles, then cleared after stall.
        resp_delay = 3;
        resp_len = 1;
        push(5'd5, 12'o120, 1);
        drain("t1_drain", 40);
        check("t1_hold", last_hold, 4);
        check("t1_count", issue_count, 1);
        resp_delay = 0;

        // JMP, TAD, DCA with stall lengths 2/4/4.
        base = issues;
        resp_len = 2;
        push(5'd0, 12'o200, 1);
        push(5'd4, 12'o201, 1);
        push(5'd2, 12'o202, 1);
        for (int i = 0; i < 20 && issues < base + 1; i++)
            @(negedge clk);
        #1;
        resp_len = 4;
        chk_gap = 1;
        drain("t2_drain", 60);
        chk_gap = 0;
        check("t2_count", issue_count, 4);

        // Fill while stall is held high in IDLE.
        resp_mode = 2;
        resp_len = 1;
        push(5'd31, 12'o0, 0);
        @(negedge clk);
        check("t3_ignored", fifo_empty, 1);
        push(5'd1, 12'o1, 1);
        push(5'd2, 12'o2, 1);
        push(5'd3, 12'o3, 1);
        push(5'd6, 12'o0, 1);
        push(5'd13, 12'o0, 1);
        push(5'd25, 12'o0, 1);
        push(5'd16, 12'o0, 1);
        push(5'd4, 12'o4, 1);
        @(negedge clk);
        check("t3_full", fifo_full, 1);
        check("t3_ready", bus.load_ready, 0);
        push(5'd0, 12'o777, 0);
        @(negedge clk);
        check("t3_full9", fifo_full, 1);
        @(posedge clk);
        #1;
        resp_mode = 0;
        bus.load_valid = 1'b1;
        bus.load_sel = 5'd1;
        bus.load_addr = 12'o55;
        sb.push_back(expv(5'd1, 12'o55));
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        @(negedge clk);
        check("t3_full_pp", fifo_full, 1);
        drain("t3_drain", 200);
        check("t3_count", issue_count, 13);

        // IAC never acknowledged.
        resp_mode = 1;
        push(5'd26, 12'o0, 1);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_now() != 0) begin
                ok = 1;
                break;
            end
        end
        check("t4_issued", ok, 1);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (op_now() == 0) begin
                ok = 1;
                break;
            end
        end
        #1;
        check("t4_cleared", ok, 1);
        check("t4_hold", last_hold, 17);
        check("t4_timeout", timeout_err, 1);
        check("t4_busy", busy, 0);
        base = issues;
        push(5'd0, 12'o12, 0);
        repeat (6) @(negedge clk);
        check("t4_frozen", fifo_empty, 0);
        check("t4_noissue", issues, base);
        check("t4_sticky", timeout_err, 1);
        resp_mode = 0;
        do_reset();

        // HLT then NOP; NOP waits for start.
        resp_len = 2;
        push(5'd15, 12'o0, 1);
        push(5'd27, 12'o0, 1);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1;
                break;
            end
        end
        check("t5_halted", ok, 1);
        repeat (5) @(negedge clk);
        #1;
        check("t5_held", fifo_empty, 0);
        check("t5_count1", issue_count, 1);
        check("t5_pending", sb.size(), 1);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain("t5_drain", 40);
        check("t5_unhalted", halted, 0);
        check("t5_count2", issue_count, 2);

        // Reset while BUSY.
        resp_len = 10;
        push(5'd4, 12'o7, 1);
        push(5'd2, 12'o11, 1);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy && bus.stall && op_now() == 0) begin
                ok = 1;
                break;
            end
        end
        check("t6_busy", ok, 1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_rbusy", busy, 0);
        check("t6_rempty", fifo_empty, 1);
        check("t6_rop", op_now(), 0);
        check("t6_rcount", issue_count, 0);
        check("t6_rhalt", halted, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb.delete();
        resp_len = 1;
        push(5'd0, 12'o3, 1);
        drain("t6_drain", 40);
        check("t6_count", issue_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
